// File: rtl/four_bit_universal_shift_pkg.sv
// Shared definitions for the universal shift register: mode codes and default width.
package four_bit_universal_shift_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHR  = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_t;

endpackage

// File: rtl/four_bit_universal_shift_cell.sv
// One bit of the universal shift register: 4:1 mode mux feeding a flop with async active-low clear.
module univ_shift_cell
   import four_bit_universal_shift_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  mode_t mode,
   input  logic  left_i,
   input  logic  right_i,
   input  logic  load_i,
   output logic  bit_o
);

   logic bit_d;
   logic bit_q;

   // Next-bit select; anything unrecognised holds the current value.
   always_comb begin
      bit_d = bit_q;
      case (mode)
         MODE_HOLD: bit_d = bit_q;
         MODE_SHR:  bit_d = left_i;
         MODE_SHL:  bit_d = right_i;
         MODE_LOAD: bit_d = load_i;
         default:   bit_d = bit_q;
      endcase
   end

   // Storage flop, cleared asynchronously while reset is low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_q <= 1'b0;
      end else begin
         bit_q <= bit_d;
      end
   end

   assign bit_o = bit_q;

endmodule

// File: rtl/four_bit_universal_shift.sv
// Parameterised universal shift register (hold / shift right / shift left / load).
// Optional serial-out taps so_r and so_l are enabled by defining UNIV_SHIFT_SOUT_EN.
module four_bit_universal_shift
   import four_bit_universal_shift_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   input  logic             clk,
   input  logic             sr,
   input  logic             sl,
   input  logic             reset,
   input  logic [1:0]       mode
`ifdef UNIV_SHIFT_SOUT_EN
   ,
   output logic             so_r,
   output logic             so_l
`endif
);

   mode_t            mode_sel;
   logic [WIDTH-1:0] bits;

   assign mode_sel = mode_t'(mode);

   // One cell per bit; the MSB takes sr on a right shift, the LSB takes sl on a left shift.
   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
      logic left_nb;
      logic right_nb;

      if (i == int'(WIDTH) - 1) begin : g_msb
         assign left_nb = sr;
      end else begin : g_mid_l
         assign left_nb = bits[i+1];
      end

      if (i == 0) begin : g_lsb
         assign right_nb = sl;
      end else begin : g_mid_r
         assign right_nb = bits[i-1];
      end

      univ_shift_cell u_cell (
         .clk     (clk),
         .reset   (reset),
         .mode    (mode_sel),
         .left_i  (left_nb),
         .right_i (right_nb),
         .load_i  (in[i]),
         .bit_o   (bits[i])
      );
   end

   assign out = bits;

`ifdef UNIV_SHIFT_SOUT_EN
   // Bits that would leave the register on the next right / left shift.
   assign so_r = bits[0];
   assign so_l = bits[WIDTH-1];
`endif

endmodule

// File: tb/tb_four_bit_universal_shift.sv
// Self-checking bench for four_bit_universal_shift: directed steps plus randomized traffic
// checked against an arithmetic reference model.
module tb_four_bit_universal_shift;

   localparam int W    = 4;
   localparam int MODV = 1 << W;

   logic [W-1:0] din;
   logic [W-1:0] dout;
   logic         clk;
   logic         sr;
   logic         sl;
   logic         reset;
   logic [1:0]   mode;
`ifdef UNIV_SHIFT_SOUT_EN
   logic         so_r;
   logic         so_l;
`endif

   int checks   = 0;
   int failures = 0;
   int model_v  = 0;

   four_bit_universal_shift #(.WIDTH(W)) dut (
      .in    (din),
      .out   (dout),
      .clk   (clk),
      .sr    (sr),
      .sl    (sl),
      .reset (reset),
      .mode  (mode)
`ifdef UNIV_SHIFT_SOUT_EN
      ,
      .so_r  (so_r),
      .so_l  (so_l)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: register value after one edge, computed with plain integer arithmetic.
   function automatic int ref_next(int v, int m, int d, int s_r, int s_l);
      case (m)
         1:       return (v / 2) + s_r * (MODV / 2);
         2:       return (v * 2 + s_l) % MODV;
         3:       return d;
         default: return v;
      endcase
   endfunction

   task automatic check_out(input string tag, input int expv);
      logic [W-1:0] e;
      e = W'(expv);
      checks++;
      assert (dout === e) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, dout, e);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic expb);
      checks++;
      assert (obs === expb) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expb);
      end
   endtask

   // Apply inputs, take one rising edge, advance the model and compare.
   task automatic step(input string tag, input int m, input int d, input int s_r, input int s_l);
      mode = 2'(m);
      din  = W'(d);
      sr   = 1'(s_r);
      sl   = 1'(s_l);
      @(posedge clk);
      #1;
      model_v = ref_next(model_v, m, d, s_r, s_l);
      check_out(tag, model_v);
   endtask

   task automatic async_reset_pulse(input string tag);
      #2 reset = 1'b0;
      #1;
      model_v = 0;
      check_out(tag, 0);
      #1 reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      mode  = 2'b11;
      din   = W'(7);
      sr    = 1'b0;
      sl    = 1'b0;

      #3 check_out("reset_state", 0);
      @(posedge clk); #1 check_out("reset_edge_load", 0);
      @(posedge clk); #1 check_out("reset_edge_load2", 0);
      reset = 1'b1;

      step("hold_after_reset", 0, 5, 1, 1);
      check_out("hold_after_reset_const", 0);

      step("load7", 3, 7, 0, 0);
      check_out("load7_const", 7);
      step("load9", 3, 9, 0, 0);
      check_out("load9_const", 9);

      step("pre_shr_load", 3, 7, 0, 0);
      step("shr1", 1, 0, 1, 0); check_out("shr1_const", 4'b1011);
      step("shr2", 1, 0, 1, 1); check_out("shr2_const", 4'b1101);
      step("shr3", 1, 15, 1, 0); check_out("shr3_const", 4'b1110);
      step("shr4", 1, 0, 1, 1); check_out("shr4_const", 4'b1111);

      step("shl1", 2, 0, 1, 0); check_out("shl1_const", 4'b1110);
      step("shl2", 2, 0, 0, 0); check_out("shl2_const", 4'b1100);
      step("shl3", 2, 9, 1, 0); check_out("shl3_const", 4'b1000);
      step("shl4", 2, 0, 0, 0); check_out("shl4_const", 4'b0000);
      step("shl_sl1_a", 2, 0, 0, 1); check_out("shl_sl1_a_const", 4'b0001);
      step("shl_sl1_b", 2, 0, 1, 1); check_out("shl_sl1_b_const", 4'b0011);

      step("pre_hold_load", 3, 10, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step("hold", 0, (i % 2 == 0) ? 5 : 15, i % 2, (i + 1) % 2);
         check_out("hold_const", 4'b1010);
      end

      step("mid_load", 3, 7, 0, 0);
      step("mid_shr", 1, 0, 1, 0);
      async_reset_pulse("mid_reset");
      step("after_mid_reset", 1, 0, 1, 0);
      check_out("after_mid_reset_const", 4'b1000);

      // Reset falling on the same step as a clock edge must leave 0.
      step("coincident_pre", 3, 13, 0, 0);
      @(posedge clk);
      reset = 1'b0;
      #1;
      model_v = 0;
      check_out("coincident_reset", 0);
      #2 reset = 1'b1;

`ifdef UNIV_SHIFT_SOUT_EN
      step("so_load9", 3, 9, 0, 0);
      check_bit("so_r_9", so_r, 1'b1);
      check_bit("so_l_9", so_l, 1'b1);
      step("so_load6", 3, 6, 0, 0);
      check_bit("so_r_6", so_r, 1'b0);
      check_bit("so_l_6", so_l, 1'b0);
`endif

      for (int i = 0; i < 300; i++) begin
         int m, d, a, b;
         m = int'($urandom_range(3, 0));
         d = int'($urandom_range(MODV - 1, 0));
         a = int'($urandom_range(1, 0));
         b = int'($urandom_range(1, 0));
         if ($urandom_range(15, 0) == 0) async_reset_pulse("rand_reset");
         step("rand", m, d, a, b);
`ifdef UNIV_SHIFT_SOUT_EN
         check_bit("rand_so_r", so_r, 1'(model_v % 2));
         check_bit("rand_so_l", so_l, 1'(model_v / (MODV / 2)));
`endif
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time bound so the run cannot hang.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
